sipo_frame_deser: RTL and testbench

- Parametrised serial-in/parallel-out frame deserialiser for the UART receive path. It sits between the RX bit sampler and the RX FIFO/host interface.
- Collects a run-time configurable number of bits, either LSB-first or MSB-first, into a right-justified word.
- Presents each completed word on a valid/ready handshake through a one-entry output buffer.
- Raises a sticky overrun flag when a completed frame cannot be delivered.

---
 rtl/sipo_frame_deser_if.sv | 11 +
 rtl/sipo_frame_deser.sv | 119 +++++++++++
 tb/tb_sipo_frame_deser.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_deser_if.sv
// Output-side handshake of the frame deserialiser: a right-justified word on valid/ready.
interface sipo_frame_deser_if #(
  parameter int MAX_WIDTH = 9
);
  logic [MAX_WIDTH-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/sipo_frame_deser.sv
// Serial-in/parallel-out frame deserialiser for the UART RX path: collects a configurable
// number of bits (LSB- or MSB-first) and hands the word over through a one-entry buffer.
module sipo_frame_deser #(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_W     = $clog2(MAX_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [CNT_W-1:0]     cfg_len,
  input  logic                 cfg_lsb_first,
  input  logic                 serial_in,
  input  logic                 shift_en,
  sipo_frame_deser_if.master   dout,
  output logic                 busy,
  output logic [CNT_W-1:0]     bit_count,
  output logic                 overrun
);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e               state_q, state_d;
  logic [MAX_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic                 lsb_q, lsb_d;
  logic [MAX_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  logic [CNT_W-1:0]     len_eff, cur_len, cnt_inc;
  logic                 first, cur_lsb, complete, xfer;
  logic [MAX_WIDTH-1:0] shifted;

  // Out-of-range lengths (0, 1, >MAX_WIDTH) fall back to a full-width frame.
  assign len_eff = (cfg_len < CNT_W'(2) || cfg_len > CNT_W'(MAX_WIDTH)) ? CNT_W'(MAX_WIDTH) : cfg_len;
  assign first   = (state_q == IDLE);
  assign cur_len = first ? len_eff : len_q;
  assign cur_lsb = first ? cfg_lsb_first : lsb_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign shifted = cur_lsb ? (shreg_q | ({{(MAX_WIDTH-1){1'b0}}, serial_in} << cnt_q))
                           : {shreg_q[MAX_WIDTH-2:0], serial_in};
  assign complete = shift_en && (cnt_inc == cur_len);
  assign xfer     = valid_q && dout.data_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    lsb_d   = lsb_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clear) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (shift_en) begin
        if (first) begin
          len_d = len_eff;
          lsb_d = cfg_lsb_first;
        end
        // Shift register is zeroed at frame end so every frame starts clean.
        if (complete) begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = COLLECT;
          shreg_d = shifted;
          cnt_d   = cnt_inc;
        end
      end
      if (xfer) valid_d = 1'b0;
      if (complete) begin
        if (!valid_q || xfer) begin
          data_d  = shifted;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      lsb_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      lsb_q   <= lsb_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout.data_out   = data_q;
  assign dout.data_valid = valid_q;
  assign busy            = (state_q == COLLECT);
  assign bit_count       = cnt_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_sipo_frame_deser.sv
// Directed bench for sipo_frame_deser: table of single frames plus hand-written corner sequences.
module tb_sipo_frame_deser;
  localparam int MW = 9;
  localparam int CW = $clog2(MW + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] cfg_len = '0;
  logic          cfg_lsb_first = 1'b0;
  logic          serial_in = 1'b0;
  logic          shift_en = 1'b0;
  logic          busy;
  logic [CW-1:0] bit_count;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  sipo_frame_deser_if #(.MAX_WIDTH(MW)) dif ();

  sipo_frame_deser #(.MAX_WIDTH(MW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .cfg_len(cfg_len),
    .cfg_lsb_first(cfg_lsb_first), .serial_in(serial_in), .shift_en(shift_en),
    .dout(dif), .busy(busy), .bit_count(bit_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // seq bit i is the i-th transmitted bit
  typedef struct {
    logic [CW-1:0] len;
    logic          lsb;
    logic [15:0]   seq;
    int            nbits;
    logic [MW-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives bits start..n-1 at negedges; bit_count is checked after each capture.
  task automatic send_bits(input logic [15:0] seq, input int start, input int n,
                           input logic [CW-1:0] len, input logic lsb, input int elen);
    for (int i = start; i < n; i++) begin
      cfg_len = len;
      cfg_lsb_first = lsb;
      serial_in = seq[i];
      shift_en = 1'b1;
      @(negedge clk);
      check("bit_count", int'(bit_count), (i + 1) % elen);
    end
  endtask

  task automatic idle();
    shift_en = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, int'(dif.data_out), 0);
    check({tag, "_valid"}, int'(dif.data_valid), 0);
    check({tag, "_count"}, int'(bit_count), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    vecs[0] = '{len: 4'd8,  lsb: 1'b1, seq: 16'h0065, nbits: 8, exp: 9'h065};
    vecs[1] = '{len: 4'd5,  lsb: 1'b0, seq: 16'h0019, nbits: 5, exp: 9'h013};
    vecs[2] = '{len: 4'd0,  lsb: 1'b1, seq: 16'h01FF, nbits: 9, exp: 9'h1FF};
    vecs[3] = '{len: 4'd3,  lsb: 1'b0, seq: 16'h0003, nbits: 3, exp: 9'h006};
    vecs[4] = '{len: 4'd1,  lsb: 1'b1, seq: 16'h0101, nbits: 9, exp: 9'h101};
    vecs[5] = '{len: 4'd15, lsb: 1'b0, seq: 16'h0001, nbits: 9, exp: 9'h100};
    vecs[6] = '{len: 4'd2,  lsb: 1'b1, seq: 16'h0002, nbits: 2, exp: 9'h002};
    vecs[7] = '{len: 4'd9,  lsb: 1'b0, seq: 16'h00AA, nbits: 9, exp: 9'h0AA};

    dif.data_ready = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: frame with consumer stalled, then one-cycle accept.
    foreach (vecs[v]) begin
      send_bits(vecs[v].seq, 0, vecs[v].nbits, vecs[v].len, vecs[v].lsb, vecs[v].nbits);
      idle();
      check($sformatf("v%0d_valid", v), int'(dif.data_valid), 1);
      check($sformatf("v%0d_data", v), int'(dif.data_out), int'(vecs[v].exp));
      check($sformatf("v%0d_overrun", v), int'(overrun), 0);
      @(negedge clk);
      check($sformatf("v%0d_hold", v), int'(dif.data_out), int'(vecs[v].exp));
      dif.data_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_consumed", v), int'(dif.data_valid), 0);
      dif.data_ready = 1'b0;
    end

    // Ready held high: valid lasts exactly one cycle.
    dif.data_ready = 1'b1;
    send_bits(16'h0065, 0, 8, 4'd8, 1'b1, 8);
    idle();
    check("rdy_valid", int'(dif.data_valid), 1);
    check("rdy_data", int'(dif.data_out), 'h65);
    @(negedge clk);
    check("rdy_valid_drop", int'(dif.data_valid), 0);
    dif.data_ready = 1'b0;

    // Back-to-back frames with consumer stalled: second is dropped.
    send_bits(16'h00A5, 0, 8, 4'd8, 1'b1, 8);
    send_bits(16'h003C, 0, 8, 4'd8, 1'b1, 8);
    idle();
    check("b2b_data", int'(dif.data_out), 'hA5);
    check("b2b_valid", int'(dif.data_valid), 1);
    check("b2b_overrun", int'(overrun), 1);
    dif.data_ready = 1'b1;
    @(negedge clk);
    dif.data_ready = 1'b0;
    check("b2b_drain_valid", int'(dif.data_valid), 0);
    check("b2b_overrun_sticky", int'(overrun), 1);

    // clear mid-frame with overrun set; the bit presented with clear is discarded.
    send_bits(16'h0007, 0, 3, 4'd8, 1'b1, 8);
    check("pre_clear_busy", int'(busy), 1);
    clear = 1'b1;
    serial_in = 1'b1;
    shift_en = 1'b1;
    dif.data_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    dif.data_ready = 1'b0;
    idle();
    check("clr_count", int'(bit_count), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_valid", int'(dif.data_valid), 0);
    check("clr_overrun", int'(overrun), 0);
    send_bits(16'h005A, 0, 8, 4'd8, 1'b1, 8);
    idle();
    check("post_clr_data", int'(dif.data_out), 'h5A);
    check("post_clr_overrun", int'(overrun), 0);
    dif.data_ready = 1'b1;
    @(negedge clk);
    dif.data_ready = 1'b0;

    // Completion on the same edge as transfer of the previous word.
    send_bits(16'h0011, 0, 8, 4'd8, 1'b1, 8);
    send_bits(16'h0022, 0, 7, 4'd8, 1'b1, 8);
    check("sim_old_held", int'(dif.data_out), 'h11);
    serial_in = 1'b0;
    dif.data_ready = 1'b1;
    @(negedge clk);
    idle();
    check("sim_valid", int'(dif.data_valid), 1);
    check("sim_data", int'(dif.data_out), 'h22);
    check("sim_overrun", int'(overrun), 0);
    @(negedge clk);
    check("sim_drain", int'(dif.data_valid), 0);
    dif.data_ready = 1'b0;

    // Config changed after bit 2 must not affect the frame in flight.
    send_bits(16'h00C3, 0, 2, 4'd8, 1'b1, 8);
    send_bits(16'h00C3, 2, 8, 4'd5, 1'b0, 8);
    idle();
    check("cfg_latch_valid", int'(dif.data_valid), 1);
    check("cfg_latch_data", int'(dif.data_out), 'hC3);
    dif.data_ready = 1'b1;
    @(negedge clk);
    dif.data_ready = 1'b0;

    // Asynchronous reset between edges with a buffered word, overrun and a partial frame.
    send_bits(16'h000F, 0, 8, 4'd8, 1'b1, 8);
    send_bits(16'h00F0, 0, 8, 4'd8, 1'b1, 8);
    send_bits(16'h0005, 0, 4, 4'd8, 1'b1, 8);
    idle();
    check("pre_rst_overrun", int'(overrun), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    send_bits(16'h0069, 0, 8, 4'd8, 1'b0, 8);
    idle();
    check("post_rst_valid", int'(dif.data_valid), 1);
    check("post_rst_data", int'(dif.data_out), 'h96);
    check("post_rst_overrun", int'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
